// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: heading controller for a snake game.
//
// Key pulses are filtered into turns: a turn equal or opposite to the current
// reference heading is dropped. Each accepted game tick moves the next pending
// turn into the heading, and step pulses one cycle later.
//
// Build option (macro SNAKE_TURN_QUEUE_EN):
//   defined   - accepted turns go into a QDEPTH-entry FIFO; a turn is checked
//               against the FIFO tail, or against dir when the FIFO is empty.
//               A turn that arrives when the FIFO is full sets overflow.
//   undefined - one pending-turn register, checked against dir and
//               overwritten by each new accepted turn; overflow stays 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   key_pulse  [0] up, [1] down, [2] left, [3] right, [4] pause (one-cycle pulses)
//   tick       one-cycle game-step strobe
//   dir        heading: 00 up, 01 down, 10 left, 11 right
//   step       one-cycle advance pulse, aligned with the updated dir
//   paused     high in PAUSE
//   running    high in RUN
//   q_count    number of pending turns
//   overflow   sticky: a valid turn was dropped because the queue was full
module snake_dir_ctrl #(
    parameter int unsigned QDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_pulse,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       step,
    output logic       paused,
    output logic       running,
    output logic [4:0] q_count,
    output logic       overflow
);

    if ((QDEPTH < 2) || (QDEPTH > 16) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_qdepth
        $error("QDEPTH must be a power of two in 2..16");
    end

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic       step_q, step_d;
    logic       ovf_q, ovf_d;

    logic       have_cand;
    logic [1:0] cand;
    logic       cand_en;   // a direction key is evaluated this cycle
    logic       tick_acc;  // tick that advances the snake this cycle
    logic [1:0] ref_dir;
    logic       valid;
    logic       push;
    logic       pop;
    logic       ovf_set;
    logic [1:0] head;

    // Highest-priority direction wins: up > down > left > right.
    always_comb begin
        have_cand = |key_pulse[3:0];
        if (key_pulse[0]) begin
            cand = 2'b00;
        end else if (key_pulse[1]) begin
            cand = 2'b01;
        end else if (key_pulse[2]) begin
            cand = 2'b10;
        end else begin
            cand = 2'b11;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_en  = 1'b0;
        tick_acc = 1'b0;
        case (state_q)
            StIdle: begin
                if (have_cand) begin
                    cand_en = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // A pause pulse masks the keys and tick of the same cycle.
                if (key_pulse[4]) begin
                    state_d = StPause;
                end else begin
                    cand_en  = have_cand;
                    // Gating on step_q keeps step from ever being high twice in a row.
                    tick_acc = tick & ~step_q;
                end
            end
            StPause: begin
                if (key_pulse[4]) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Up/down and left/right differ only in bit 0, so the opposite is ref ^ 1.
    assign valid = cand_en && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));

`ifdef SNAKE_TURN_QUEUE_EN
    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(QDEPTH);

    logic [1:0]      mem_q [QDEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        // Reference is the newest queued turn, sampled before any same-cycle pop.
        ref_dir  = (cnt_q != '0) ? mem_q[wr_ptr_q - PtrW'(1)] : dir_q;
        head     = mem_q[rd_ptr_q];
        pop      = tick_acc && (cnt_q != '0);
        // A full queue still accepts a turn when the head leaves in the same cycle.
        push     = valid && ((cnt_q != CntFull) || pop);
        ovf_set  = valid && !push;
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cand;
        end
    end

    assign q_count = 5'(cnt_q);
`else
    logic       pend_valid_q, pend_valid_d;
    logic [1:0] pend_q, pend_d;

    always_comb begin
        ref_dir      = dir_q;
        head         = pend_q;
        pop          = tick_acc && pend_valid_q;
        push         = valid;
        ovf_set      = 1'b0;
        pend_d       = push ? cand : pend_q;
        pend_valid_d = push | (pend_valid_q & ~pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_q       <= 2'b00;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    assign q_count = {4'b0000, pend_valid_q};
`endif

    always_comb begin
        dir_d  = pop ? head : dir_q;
        step_d = tick_acc;
        ovf_d  = ovf_q | ovf_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dir_q   <= 2'b11;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dir      = dir_q;
    assign step     = step_q;
    assign paused   = (state_q == StPause);
    assign running  = (state_q == StRun);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl (either build of SNAKE_TURN_QUEUE_EN).
// A behavioural model built on a SystemVerilog queue predicts the outputs for
// every driven cycle; predictions go through a scoreboard queue and are
// compared one cycle later. Directed scenarios add literal expectations.
module tb_snake_dir_ctrl;

    localparam int unsigned QD = 4;

    logic       clk;
    logic       rst;
    logic [4:0] key_pulse;
    logic       tick;
    logic [1:0] dir;
    logic       step;
    logic       paused;
    logic       running;
    logic [4:0] q_count;
    logic       overflow;

    snake_dir_ctrl #(.QDEPTH(QD)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .tick      (tick),
        .dir       (dir),
        .step      (step),
        .paused    (paused),
        .running   (running),
        .q_count   (q_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] dir;
        logic       step;
        logic       paused;
        logic       running;
        logic [4:0] qc;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 idle, 1 run, 2 pause.
    int         m_state;
    logic [1:0] m_dir;
    logic       m_step;
    logic       m_ovf;
    logic [1:0] m_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_dir   = 2'b11;
        m_step  = 1'b0;
        m_ovf   = 1'b0;
        m_q.delete();
    endtask

    task automatic model_cycle(input logic [4:0] kp, input logic tk);
        logic [1:0] cand;
        logic [1:0] rf;
        bit         consider;
        bit         tk_acc;
        consider = 0;
        tk_acc   = 0;
        if (kp[0])      cand = 2'b00;
        else if (kp[1]) cand = 2'b01;
        else if (kp[2]) cand = 2'b10;
        else            cand = 2'b11;
        case (m_state)
            0: if (kp[3:0] != 4'b0) begin consider = 1; m_state = 1; end
            1: begin
                if (kp[4]) m_state = 2;
                else begin
                    consider = (kp[3:0] != 4'b0);
                    tk_acc   = tk;
                end
            end
            default: if (kp[4]) m_state = 1;
        endcase
`ifdef SNAKE_TURN_QUEUE_EN
        rf = (m_q.size() > 0) ? m_q[$] : m_dir;
`else
        rf = m_dir;
`endif
        if (consider && (cand == rf || cand == (rf ^ 2'b01))) consider = 0;
        if (tk_acc && m_q.size() > 0) m_dir = m_q.pop_front();
`ifdef SNAKE_TURN_QUEUE_EN
        if (consider) begin
            if (m_q.size() < QD) m_q.push_back(cand);
            else m_ovf = 1'b1;
        end
`else
        if (consider) begin
            m_q.delete();
            m_q.push_back(cand);
        end
`endif
        m_step = tk_acc;
    endtask

    // Drive one cycle, predict, then compare just after the active edge.
    task automatic cycle(input logic [4:0] kp, input logic tk);
        exp_t e;
        key_pulse = kp;
        tick      = tk;
        model_cycle(kp, tk);
        e.dir     = m_dir;
        e.step    = m_step;
        e.paused  = (m_state == 2);
        e.running = (m_state == 1);
        e.qc      = 5'(m_q.size());
        e.ovf     = m_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        key_pulse = '0;
        tick      = 1'b0;
        e = exp_q.pop_front();
        check_eq("dir",      32'(dir),      32'(e.dir));
        check_eq("step",     32'(step),     32'(e.step));
        check_eq("paused",   32'(paused),   32'(e.paused));
        check_eq("running",  32'(running),  32'(e.running));
        check_eq("q_count",  32'(q_count),  32'(e.qc));
        check_eq("overflow", 32'(overflow), 32'(e.ovf));
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        check_eq("rst_dir",      32'(dir),      32'd3);
        check_eq("rst_step",     32'(step),     32'd0);
        check_eq("rst_paused",   32'(paused),   32'd0);
        check_eq("rst_running",  32'(running),  32'd0);
        check_eq("rst_q_count",  32'(q_count),  32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] kp;
        logic       tk;
        logic       last_tk;
        int         r;
        logic [1:0] exp_dirs [4];

        rst       = 1'b0;
        key_pulse = '0;
        tick      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle ignores tick and pause; first direction key starts the game.
        cycle(5'h00, 1'b1);
        cycle(5'h10, 1'b0);
        check_eq("idle_running", 32'(running), 32'd0);
        cycle(5'h01, 1'b0);
        check_eq("start_running", 32'(running), 32'd1);
        check_eq("start_qcount",  32'(q_count), 32'd1);
        cycle(5'h00, 1'b1);
        check_eq("tick1_dir",  32'(dir),     32'd0);
        check_eq("tick1_step", 32'(step),    32'd1);
        check_eq("tick1_qcnt", 32'(q_count), 32'd0);
        cycle(5'h00, 1'b0);
        check_eq("tick1_step_off", 32'(step), 32'd0);

        // Opposite turn is dropped silently; empty-queue tick still steps.
        cycle(5'h02, 1'b0);
        check_eq("opp_qcnt", 32'(q_count),  32'd0);
        check_eq("opp_ovf",  32'(overflow), 32'd0);
        cycle(5'h00, 1'b1);
        check_eq("empty_tick_dir",  32'(dir),  32'd0);
        check_eq("empty_tick_step", 32'(step), 32'd1);
        cycle(5'h00, 1'b0);

        // Fill past capacity, then drain.
        do_reset();
        cycle(5'h01, 1'b0);
        cycle(5'h04, 1'b0);
        cycle(5'h02, 1'b0);
        cycle(5'h08, 1'b0);
        cycle(5'h01, 1'b0);
`ifdef SNAKE_TURN_QUEUE_EN
        check_eq("full_qcnt", 32'(q_count),  32'd4);
        check_eq("full_ovf",  32'(overflow), 32'd1);
        exp_dirs = '{2'b00, 2'b10, 2'b01, 2'b11};
`else
        check_eq("pend_qcnt", 32'(q_count),  32'd1);
        check_eq("pend_ovf",  32'(overflow), 32'd0);
        exp_dirs = '{2'b00, 2'b00, 2'b00, 2'b00};
`endif
        for (int i = 0; i < 4; i++) begin
            cycle(5'h00, 1'b1);
            check_eq("drain_dir", 32'(dir), 32'(exp_dirs[i]));
            cycle(5'h00, 1'b0);
        end

        // Full queue with key and tick together.
        cycle(5'h01, 1'b0);
        cycle(5'h04, 1'b0);
        cycle(5'h02, 1'b0);
        cycle(5'h08, 1'b0);
        cycle(5'h01, 1'b1);
`ifdef SNAKE_TURN_QUEUE_EN
        check_eq("fullpp_qcnt", 32'(q_count), 32'd4);
        check_eq("fullpp_dir",  32'(dir),     32'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            cycle(5'h00, 1'b0);
            cycle(5'h00, 1'b1);
        end
        cycle(5'h00, 1'b0);

        // Pause: ticks and keys ignored, queue preserved.
        cycle(5'h04, 1'b0);
        cycle(5'h10, 1'b0);
        check_eq("pause_on", 32'(paused), 32'd1);
        cycle(5'h00, 1'b1);
        cycle(5'h00, 1'b0);
        cycle(5'h04, 1'b1);
        cycle(5'h00, 1'b1);
        check_eq("pause_step", 32'(step), 32'd0);
        cycle(5'h10, 1'b0);
        check_eq("pause_off", 32'(paused),  32'd0);
        check_eq("pause_run", 32'(running), 32'd1);
        cycle(5'h00, 1'b1);
        cycle(5'h00, 1'b0);

        // Up then down before a tick.
        do_reset();
        cycle(5'h01, 1'b0);
        cycle(5'h02, 1'b0);
        cycle(5'h00, 1'b1);
`ifndef SNAKE_TURN_QUEUE_EN
        check_eq("pend_over_dir", 32'(dir),      32'd1);
        check_eq("pend_over_ovf", 32'(overflow), 32'd0);
`else
        check_eq("q_opp_dir", 32'(dir), 32'd0);
`endif
        cycle(5'h00, 1'b0);

        // Random traffic with occasional mid-operation resets.
        last_tk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 150 || i == 300) begin
                do_reset();
                last_tk = 1'b0;
            end
            kp = '0;
            r  = $urandom_range(0, 9);
            if (r < 4)       kp[3:0] = 4'($urandom_range(1, 15));
            else if (r == 4) kp[4]   = 1'b1;
            else if (r == 5) kp      = 5'($urandom_range(0, 31));
            tk = !last_tk && ($urandom_range(0, 2) == 0);
            last_tk = tk;
            cycle(kp, tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter QDEPTH, default 4: turn-queue depth, power of two, 2..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 key_pulse  input  5  one-cycle active-high debounced key pulses: bit0 up, bit1 down, bit2 left, bit3 right, bit4 pause.
REQ-005 tick  input  1  one-cycle game-step strobe from the game timer.
REQ-006 dir  output  2  current snake heading: 00 up, 01 down, 10 left, 11 right.
REQ-007 step  output  1  one-cycle pulse: the snake advances one cell in heading dir.
REQ-008 paused  output  1  high while in state PAUSE.
REQ-009 running  output  1  high while in state RUN.
REQ-010 q_count  output  5  number of queued turns.
REQ-011 overflow  output  1  sticky flag: a valid turn was dropped because the queue was full.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and PAUSE.
REQ-013 IDLE: tick is ignored; the first cycle with any direction bit set SHALL enqueue that direction and move to RUN; pause is ignored.
REQ-014 RUN: a pause pulse SHALL move to PAUSE; the ticks and direction bits of that same cycle are ignored.
REQ-015 PAUSE: tick and direction bits are ignored; a pause pulse SHALL return to RUN; queue contents are preserved.
REQ-016 Multiple direction bits in one cycle: only the highest-priority bit is considered (up > down > left > right).
REQ-017 Candidate turn reference = queue tail if q_count>0, else dir, evaluated before any same-cycle pop.
REQ-018 A candidate equal or opposite to the reference SHALL be dropped silently; overflow is not set.
REQ-019 A valid candidate SHALL be pushed at the tail when q_count<QDEPTH; otherwise dropped, and overflow set to 1.
REQ-020 tick in RUN: if q_count>0, the head SHALL be popped into dir; step SHALL pulse in the cycle after tick, aligned with the updated dir.
REQ-021 tick in RUN with an empty queue: dir is unchanged and step still pulses one cycle later.
REQ-022 Push and pop in the same cycle: both SHALL occur, and q_count is unchanged; this holds when full.
REQ-023 Push into an empty queue on a tick cycle: no pop; the turn applies on the next tick.
REQ-024 q_count SHALL never exceed QDEPTH; queue pointers wrap modulo QDEPTH.
REQ-025 step SHALL never be high outside RUN and SHALL never be high for two consecutive cycles.

Reset
REQ-026 While rst=0: state IDLE, dir=11 (right), step=0, paused=0, running=0, q_count=0, overflow=0, queue pointers 0.
REQ-027 A reset asserted mid-operation SHALL discard queued turns immediately; operation resumes in IDLE on the first clk after release.
REQ-028 overflow is cleared only by reset.

Configuration
REQ-029 Macro SNAKE_TURN_QUEUE_EN defined: the QDEPTH-entry FIFO behaviour in REQ-017..REQ-024 applies.
REQ-030 Macro SNAKE_TURN_QUEUE_EN undefined: a single pending-turn register replaces the FIFO.
REQ-031 In that build, the reference is always dir.
REQ-032 In that build, an accepted turn overwrites the pending register; a tick consumes it.
REQ-033 In that build, q_count is 0 or 1, and overflow is held at 0.

Verification (SNAKE_TURN_QUEUE_EN defined, QDEPTH=4 unless noted)
REQ-034 Reset, then key up, then tick -> running=1, q_count 1->0, dir=00, step pulse one cycle after tick.
REQ-035 dir=00, empty queue, key down -> dropped; q_count=0, overflow=0; next tick leaves dir=00 and step still pulses.
REQ-036 dir=11, keys up, left, down, right, up on five cycles, no tick -> q_count=4, overflow=1, ticks pop dir 00,10,01,11 in order.
REQ-037 Queue full plus key and tick in the same cycle -> q_count stays 4, head popped, and the new turn is appended.
REQ-038 RUN, pause, 3 ticks plus key left, pause -> paused=1 then 0, no step and dir unchanged while paused, q_count unchanged.
REQ-039 SNAKE_TURN_QUEUE_EN undefined, dir=11, keys up then down before a tick -> pending=01, tick gives dir=01, overflow=0.
